// File: rtl/cpu_pkg.sv
// Shared opcode map and control enums for the accumulator CPU sequencer and datapath.
package cpu_pkg;

  localparam int unsigned OPC_W = 8;

  localparam logic [OPC_W-1:0] NOP   = 8'h00;
  localparam logic [OPC_W-1:0] LOAD  = 8'h01;
  localparam logic [OPC_W-1:0] STO   = 8'h02;
  localparam logic [OPC_W-1:0] SUM   = 8'h03;
  localparam logic [OPC_W-1:0] SUB   = 8'h04;
  localparam logic [OPC_W-1:0] MULTI = 8'h05;
  localparam logic [OPC_W-1:0] DIV   = 8'h06;
  localparam logic [OPC_W-1:0] JUMP  = 8'h07;
  localparam logic [OPC_W-1:0] TST   = 8'h08;
  localparam logic [OPC_W-1:0] OUT   = 8'h09;
  localparam logic [OPC_W-1:0] IN    = 8'h0A;
  localparam logic [OPC_W-1:0] HLT   = 8'h0F;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_READ,
    S_EXEC,
    S_WRITE,
    S_PAUSE,
    S_HALT
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_MUL = 2'd2,
    ALU_DIV = 2'd3
  } alu_op_t;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'd0,
    SRC_RAM  = 2'd1,
    SRC_PORT = 2'd2
  } acc_src_t;

  function automatic alu_op_t alu_of(input logic [OPC_W-1:0] op);
    alu_op_t r;
    case (op)
      SUB:     r = ALU_SUB;
      MULTI:   r = ALU_MUL;
      DIV:     r = ALU_DIV;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute control FSM with RAM stall handshake,
// single-step pause and halt/illegal-opcode trap.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned OPC_BITS    = 8,
  parameter int unsigned ALU_OP_BITS = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [OPC_BITS-1:0]    opcode,
  input  logic                   acc_zero,
  input  logic                   mem_ready,
  input  logic                   step_mode,
  input  logic                   step,
  output logic                   ir_load,
  output logic                   pc_inc,
  output logic                   pc_skip,
  output logic                   pc_load,
  output logic                   ram_re,
  output logic                   ram_we,
  output logic                   acc_load,
  output logic [1:0]             acc_src,
  output logic [ALU_OP_BITS-1:0] alu_op,
  output logic                   port_out_load,
  output logic                   halted,
  output logic                   illegal
);

  state_t              state_q, state_d;
  logic [OPC_BITS-1:0] ir_q, ir_d;
  logic                illegal_q, illegal_d;

  logic     ir_load_c, pc_inc_c, pc_skip_c, pc_load_c;
  logic     ram_re_c, ram_we_c, acc_load_c, port_out_load_c;
  acc_src_t acc_src_c;
  alu_op_t  alu_op_c;
  state_t   end_state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    ir_d            = ir_q;
    illegal_d       = illegal_q;
    ir_load_c       = 1'b0;
    pc_inc_c        = 1'b0;
    pc_skip_c       = 1'b0;
    pc_load_c       = 1'b0;
    ram_re_c        = 1'b0;
    ram_we_c        = 1'b0;
    acc_load_c      = 1'b0;
    port_out_load_c = 1'b0;
    acc_src_c       = SRC_ALU;
    alu_op_c        = ALU_ADD;
    end_state       = step_mode ? S_PAUSE : S_FETCH;

    case (state_q)
      S_FETCH: begin
        ir_load_c = 1'b1;
        ir_d      = opcode;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        case (ir_q)
          LOAD, SUM, SUB, MULTI, DIV: state_d = S_READ;
          STO:                        state_d = S_WRITE;
          NOP, IN, OUT, JUMP, TST:    state_d = S_EXEC;
          HLT: begin
            state_d   = S_HALT;
            illegal_d = 1'b0;
          end
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_READ: begin
        ram_re_c = 1'b1;
        if (mem_ready) state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = end_state;
        case (ir_q)
          LOAD: begin
            acc_load_c = 1'b1;
            acc_src_c  = SRC_RAM;
            pc_inc_c   = 1'b1;
          end
          SUM, SUB, MULTI, DIV: begin
            acc_load_c = 1'b1;
            acc_src_c  = SRC_ALU;
            alu_op_c   = alu_of(ir_q);
            pc_inc_c   = 1'b1;
          end
          IN: begin
            acc_load_c = 1'b1;
            acc_src_c  = SRC_PORT;
            pc_inc_c   = 1'b1;
          end
          OUT: begin
            port_out_load_c = 1'b1;
            pc_inc_c        = 1'b1;
          end
          JUMP:    pc_load_c = 1'b1;
          TST: begin
            pc_skip_c = acc_zero;
            pc_inc_c  = ~acc_zero;
          end
          default: pc_inc_c = 1'b1;
        endcase
      end
      S_WRITE: begin
        ram_we_c = 1'b1;
        if (mem_ready) begin
          pc_inc_c = 1'b1;
          state_d  = end_state;
        end
      end
      S_PAUSE: begin
        if (step || !step_mode) state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Outputs are forced low while reset is held so a stalled RAM cycle is dropped immediately.
  assign ir_load       = ~reset & ir_load_c;
  assign pc_inc        = ~reset & pc_inc_c;
  assign pc_skip       = ~reset & pc_skip_c;
  assign pc_load       = ~reset & pc_load_c;
  assign ram_re        = ~reset & ram_re_c;
  assign ram_we        = ~reset & ram_we_c;
  assign acc_load      = ~reset & acc_load_c;
  assign port_out_load = ~reset & port_out_load_c;
  assign acc_src       = reset ? '0 : 2'(acc_src_c);
  assign alu_op        = reset ? '0 : ALU_OP_BITS'(alu_op_c);
  assign halted        = ~reset & (state_q == S_HALT);
  assign illegal       = ~reset & illegal_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized instruction-stream bench for cpu_sequencer with a per-instruction cycle model.
module tb_cpu_sequencer;

  localparam logic [7:0] T_NOP = 8'h00, T_LOAD = 8'h01, T_STO = 8'h02, T_SUM = 8'h03;
  localparam logic [7:0] T_SUB = 8'h04, T_MULTI = 8'h05, T_DIV = 8'h06, T_JUMP = 8'h07;
  localparam logic [7:0] T_TST = 8'h08, T_OUT = 8'h09, T_IN = 8'h0A, T_HLT = 8'h0F;

  // Observation vector: {ir_load,pc_inc,pc_skip,pc_load,ram_re,ram_we,acc_load,acc_src,alu_op,port_out_load,halted,illegal}
  localparam logic [13:0] B_IR   = 14'h2000;
  localparam logic [13:0] B_INC  = 14'h1000;
  localparam logic [13:0] B_SKIP = 14'h0800;
  localparam logic [13:0] B_LD   = 14'h0400;
  localparam logic [13:0] B_RE   = 14'h0200;
  localparam logic [13:0] B_WE   = 14'h0100;
  localparam logic [13:0] B_AL   = 14'h0080;
  localparam logic [13:0] B_PO   = 14'h0004;
  localparam logic [13:0] B_H    = 14'h0002;
  localparam logic [13:0] B_IL   = 14'h0001;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] opcode;
  logic       acc_zero, mem_ready, step_mode, step;
  logic       ir_load, pc_inc, pc_skip, pc_load, ram_re, ram_we, acc_load;
  logic [1:0] acc_src, alu_op;
  logic       port_out_load, halted, illegal;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [7:0] legal_ops [11] = '{T_NOP, T_LOAD, T_STO, T_SUM, T_SUB, T_MULTI,
                                 T_DIV, T_JUMP, T_TST, T_OUT, T_IN};

  cpu_sequencer #(.OPC_BITS(8), .ALU_OP_BITS(2)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .acc_zero(acc_zero),
    .mem_ready(mem_ready), .step_mode(step_mode), .step(step),
    .ir_load(ir_load), .pc_inc(pc_inc), .pc_skip(pc_skip), .pc_load(pc_load),
    .ram_re(ram_re), .ram_we(ram_we), .acc_load(acc_load), .acc_src(acc_src),
    .alu_op(alu_op), .port_out_load(port_out_load), .halted(halted), .illegal(illegal)
  );

  always #5 clock = ~clock;

  // Called at a negedge after inputs are set; checks then advances to the next negedge.
  task automatic chk(input logic [13:0] exp, input string tag);
    logic [13:0] got;
    #1;
    got = {ir_load, pc_inc, pc_skip, pc_load, ram_re, ram_we, acc_load,
           acc_src, alu_op, port_out_load, halted, illegal};
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic logic [13:0] exec_exp(input logic [7:0] op, input logic az);
    logic [7:0] d;
    d = op - T_SUM;
    if (op == T_LOAD)                    return B_AL | (14'd1 << 5) | B_INC;
    if (op inside {T_SUM, T_SUB, T_MULTI, T_DIV})
      return B_AL | (14'(d[1:0]) << 3) | B_INC;
    if (op == T_IN)                      return B_AL | (14'd2 << 5) | B_INC;
    if (op == T_OUT)                     return B_PO | B_INC;
    if (op == T_JUMP)                    return B_LD;
    if (op == T_TST)                     return az ? B_SKIP : B_INC;
    return B_INC;
  endfunction

  task automatic run_instr(input logic [7:0] op, input int nwait, input logic az,
                           input logic sm, input int pause_len, input logic by_step);
    step_mode = sm; acc_zero = az; step = 1'b0;
    opcode = op; mem_ready = 1'($urandom);
    chk(B_IR, "fetch");
    opcode = 8'($urandom); mem_ready = 1'($urandom);
    chk('0, "decode");
    if (op inside {T_LOAD, T_SUM, T_SUB, T_MULTI, T_DIV}) begin
      for (int i = 0; i < nwait; i++) begin
        mem_ready = 1'b0; chk(B_RE, "read_wait");
      end
      mem_ready = 1'b1; chk(B_RE, "read_done");
      opcode = 8'($urandom); mem_ready = 1'($urandom);
      chk(exec_exp(op, az), "exec_read");
    end else if (op == T_STO) begin
      for (int i = 0; i < nwait; i++) begin
        mem_ready = 1'b0; chk(B_WE, "write_wait");
      end
      mem_ready = 1'b1; chk(B_WE | B_INC, "write_done");
    end else begin
      chk(exec_exp(op, az), "exec");
    end
    if (sm) begin
      for (int i = 0; i < pause_len; i++) begin
        mem_ready = 1'($urandom); chk('0, "pause");
      end
      if (by_step) step = 1'b1; else step_mode = 1'b0;
      chk('0, "pause_exit");
      step = 1'b0;
    end
  endtask

  task automatic run_halt(input logic [7:0] op);
    logic [13:0] hx;
    hx = B_H | ((op == T_HLT) ? 14'd0 : B_IL);
    step_mode = 1'b0; step = 1'b0; opcode = op; mem_ready = 1'b1;
    chk(B_IR, "halt_fetch");
    opcode = 8'($urandom);
    chk('0, "halt_decode");
    for (int i = 0; i < 4; i++) begin
      step = 1'($urandom); step_mode = 1'($urandom); mem_ready = 1'($urandom);
      acc_zero = 1'($urandom); opcode = 8'($urandom);
      chk(hx, "halted");
    end
    step = 1'b0; step_mode = 1'b0;
    reset = 1'b1; chk('0, "halt_reset");
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; opcode = '0; acc_zero = 1'b0; mem_ready = 1'b0;
    step_mode = 1'b0; step = 1'b0;
    @(negedge clock);
    chk('0, "reset0");
    chk('0, "reset1");
    reset = 1'b0;

    // Reset in the middle of a stalled write.
    opcode = T_STO; mem_ready = 1'b1;
    chk(B_IR, "rw_fetch");
    chk('0, "rw_decode");
    mem_ready = 1'b0; chk(B_WE, "rw_write");
    reset = 1'b1; chk('0, "rw_reset");
    chk('0, "rw_reset_hold");
    reset = 1'b0;

    run_instr(T_SUM,  0, 1'b0, 1'b0, 0, 1'b0);
    run_instr(T_LOAD, 3, 1'b0, 1'b0, 0, 1'b0);
    run_instr(T_TST,  0, 1'b1, 1'b0, 0, 1'b0);
    run_instr(T_TST,  0, 1'b0, 1'b0, 0, 1'b0);
    run_instr(T_JUMP, 0, 1'b0, 1'b0, 0, 1'b0);
    run_instr(T_NOP,  0, 1'b0, 1'b1, 10, 1'b1);
    run_instr(T_OUT,  0, 1'b0, 1'b1, 2, 1'b0);
    run_halt(8'hFF);
    run_halt(T_HLT);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 24) == 0) begin
        logic [7:0] bad;
        bad = 8'($urandom_range(8'h0B, 8'hFF));
        if (bad == T_HLT && $urandom_range(0, 1) == 0) bad = 8'hFF;
        run_halt(bad);
      end else begin
        run_instr(legal_ops[$urandom_range(0, 10)], $urandom_range(0, 3),
                  1'($urandom), ($urandom_range(0, 3) == 0),
                  $urandom_range(0, 3), 1'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
